// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU front end.
//   DATA_W   : operand / result width
//   op_e     : opcode encoding entered on sw[2:0]
//   state_e  : entry / execute FSM states
//   alu_comb : result and flags for every single-cycle opcode
package alu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOTA = 3'd5,
    OP_MUL  = 3'd6,
    OP_SHL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              ovf;
  } alu_res_t;

  // Multiply is iterated in the top, so this function returns zeros for it.
  function automatic alu_res_t alu_comb(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input op_e op);
    alu_res_t            r;
    logic [DATA_W:0]     s5;
    logic [2*DATA_W-1:0] ext;
    r   = '0;
    s5  = '0;
    ext = '0;
    case (op)
      OP_ADD: begin
        s5      = {1'b0, a} + {1'b0, b};
        r.res   = s5[DATA_W-1:0];
        r.carry = s5[DATA_W];
        r.ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (s5[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        s5      = {1'b0, a} - {1'b0, b};
        r.res   = s5[DATA_W-1:0];
        r.carry = (a < b);
        r.ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (s5[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_XOR:  r.res = a ^ b;
      OP_NOTA: r.res = ~a;
      OP_MUL:  r = '0;
      OP_SHL: begin
        // Widened shift: bit DATA_W holds the last bit pushed out (0 for shift 0).
        ext     = {{DATA_W{1'b0}}, a} << b[1:0];
        r.res   = ext[DATA_W-1:0];
        r.carry = ext[DATA_W];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, stability counter and
// falling-edge detector on the accepted level.
//   clk, rst_n : clock, async active-low reset
//   key_n_i    : raw active-low button (asynchronous, bouncy)
//   press_o    : one-cycle pulse when a new press is accepted
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced level disagrees with the accepted
  // one; any return to the accepted level (a bounce) clears it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential 4-bit ALU: operand A, operand B and opcode are entered on the
// switches, each confirmed with one debounced press; the result is held with
// its flags until the next computation completes.
//   clk, rst_n : clock, async active-low reset
//   key_n      : raw active-low pushbutton
//   sw         : operand value, or opcode in sw[2:0]
//   aluout     : registered result nibble
//   carry, ovf, zero : registered status flags
//   valid      : result of the latest entry sequence is displayed
//   stage      : entry step (0 A, 1 B, 2 opcode, 3 exec/done)
//
// Handshake: there is none beyond the button; press is a single-cycle event,
// and valid rises on the same edge that loads aluout and the flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] aluout,
  output logic              carry,
  output logic              ovf,
  output logic              zero,
  output logic              valid,
  output logic [1:0]        stage
);

  logic press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_n),
    .press_o (press)
  );

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  op_e                 op_q, op_d;
  logic [1:0]          iter_q, iter_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   aluout_q, aluout_d;
  logic                carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic                valid_q, valid_d;

  alu_res_t            op_res;
  logic [2*DATA_W-1:0] addend, prod_next;

  always_comb begin
    op_res    = alu_comb(a_q, b_q, op_q);
    // Shift-add step: partial product for multiplier bit iter_q.
    addend    = b_q[iter_q] ? ({{DATA_W{1'b0}}, a_q} << iter_q) : '0;
    prod_next = prod_q + addend;

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    iter_d   = iter_q;
    prod_d   = prod_q;
    aluout_d = aluout_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    valid_d  = valid_q;

    case (state_q)
      S_GET_A: if (press) begin
        a_d     = sw;
        state_d = S_GET_B;
      end
      S_GET_B: if (press) begin
        b_d     = sw;
        state_d = S_GET_OP;
      end
      S_GET_OP: if (press) begin
        op_d    = op_e'(sw[2:0]);
        iter_d  = 2'd0;
        prod_d  = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          prod_d = prod_next;
          iter_d = iter_q + 2'd1;
          // Outputs are untouched until the last step, so no partial product shows.
          if (iter_q == 2'd3) begin
            aluout_d = prod_next[DATA_W-1:0];
            carry_d  = |prod_next[2*DATA_W-1:DATA_W];
            ovf_d    = 1'b0;
            zero_d   = (prod_next[DATA_W-1:0] == '0);
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
          aluout_d = op_res.res;
          carry_d  = op_res.carry;
          ovf_d    = op_res.ovf;
          zero_d   = (op_res.res == '0);
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: if (press) begin
        valid_d = 1'b0;
        state_d = S_GET_A;
      end
      default: state_d = S_GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_GET_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      iter_q   <= 2'd0;
      prod_q   <= '0;
      aluout_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      iter_q   <= iter_d;
      prod_q   <= prod_d;
      aluout_q <= aluout_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    case (state_q)
      S_GET_A:  stage = 2'd0;
      S_GET_B:  stage = 2'd1;
      S_GET_OP: stage = 2'd2;
      default:  stage = 2'd3;
    endcase
  end

  assign aluout = aluout_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed operand/opcode entries through the button
// path, expected results queued at entry and checked when valid rises.
module tb_alu_seq;

  localparam int DB = 4;
  localparam int W  = 10;  // {latency[2:0], zero, ovf, carry, res[3:0]}

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] sw    = 4'd0;
  logic [3:0] aluout;
  logic       carry, ovf, zero, valid;
  logic [1:0] stage;

  alu_seq #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .sw     (sw),
    .aluout (aluout),
    .carry  (carry),
    .ovf    (ovf),
    .zero   (zero),
    .valid  (valid),
    .stage  (stage)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [3:0] res, input logic c,
                                            input logic o, input logic [2:0] lat);
    return {lat, (res == 4'd0), o, c, res};
  endfunction

  // ---------------- monitor ----------------
  int           mon_cyc = 0;
  int           s3_cyc  = 0;
  logic         prev_valid = 1'b0;
  logic [1:0]   prev_stage = 2'd0;
  logic [W-1:0] mon_e;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (stage == 2'd3 && prev_stage != 2'd3) s3_cyc = mon_cyc;
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: aluout=%0h with no expected entry", aluout);
        end else begin
          mon_e = exp_q.pop_front();
          check("aluout",  {4'd0, aluout}, {4'd0, mon_e[3:0]});
          check("carry",   {7'd0, carry},  {7'd0, mon_e[4]});
          check("ovf",     {7'd0, ovf},    {7'd0, mon_e[5]});
          check("zero",    {7'd0, zero},   {7'd0, mon_e[6]});
          check("latency", 8'(mon_cyc - s3_cyc), {5'd0, mon_e[9:7]});
        end
      end
      prev_valid = valid;
      prev_stage = stage;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_key();
    @(negedge clk);
    key_n = 1'b0;
    repeat (6) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_stage(input logic [1:0] target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stage == target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("wait_stage_timeout", {6'd0, stage}, {6'd0, target});
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] res, input logic c, input logic o,
                        input logic [2:0] lat, input bit ret);
    sw = a;
    press_key();
    check("stage_b", {6'd0, stage}, 8'd1);
    sw = b;
    press_key();
    check("stage_op", {6'd0, stage}, 8'd2);
    sw = {1'b0, op};
    exp_q.push_back(pack_exp(res, c, o, lat));
    press_key();
    check("stage_done", {6'd0, stage}, 8'd3);
    check("valid_done", {7'd0, valid}, 8'd1);
    if (ret) begin
      press_key();
      check("stage_ret", {6'd0, stage}, 8'd0);
      check("valid_ret", {7'd0, valid}, 8'd0);
      check("aluout_hold", {4'd0, aluout}, {4'd0, res});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_aluout"}, {4'd0, aluout}, 8'd0);
    check({tag, "_zero"},   {7'd0, zero},   8'd1);
    check({tag, "_carry"},  {7'd0, carry},  8'd0);
    check({tag, "_ovf"},    {7'd0, ovf},    8'd0);
    check({tag, "_valid"},  {7'd0, valid},  8'd0);
    check({tag, "_stage"},  {6'd0, stage},  8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //     A      B      op    res    c     o     lat
    run_op(4'h7, 4'h1, 3'd0, 4'h8, 1'b0, 1'b1, 3'd1, 1'b1);
    run_op(4'h7, 4'h9, 3'd0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1);
    run_op(4'h8, 4'h1, 3'd1, 4'h7, 1'b0, 1'b1, 3'd1, 1'b1);
    run_op(4'hC, 4'hA, 3'd2, 4'h8, 1'b0, 1'b0, 3'd1, 1'b1);
    run_op(4'hC, 4'hA, 3'd3, 4'hE, 1'b0, 1'b0, 3'd1, 1'b1);
    run_op(4'hC, 4'hA, 3'd4, 4'h6, 1'b0, 1'b0, 3'd1, 1'b1);
    run_op(4'hC, 4'hA, 3'd5, 4'h3, 1'b0, 1'b0, 3'd1, 1'b1);
    run_op(4'hB, 4'h3, 3'd7, 4'h8, 1'b1, 1'b0, 3'd1, 1'b1);
    run_op(4'h9, 4'h4, 3'd7, 4'h9, 1'b0, 1'b0, 3'd1, 1'b1);
    run_op(4'h3, 4'h5, 3'd1, 4'hE, 1'b1, 1'b0, 3'd1, 1'b0);

    // Mid-run reset while a result is displayed.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Bouncy press then bouncy release: exactly one capture (A = 6).
    sw = 4'h6;
    for (int i = 0; i < 6; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    key_n = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      key_n = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) @(negedge clk);
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_stage", {6'd0, stage}, 8'd1);

    sw = 4'h7;
    press_key();
    check("mul_stage_op", {6'd0, stage}, 8'd2);

    // 6 * 7 = 42 = 0x2A; button chatters while the multiply runs.
    sw = 4'h6;
    exp_q.push_back(pack_exp(4'hA, 1'b1, 1'b0, 3'd4));
    @(negedge clk);
    key_n = 1'b0;
    wait_stage(2'd3, 40);
    for (int i = 0; i < 4; i++) begin
      key_n = ~key_n;
      @(negedge clk);
      check("exec_stage", {6'd0, stage}, 8'd3);
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mul_stage_done", {6'd0, stage}, 8'd3);
    check("mul_valid", {7'd0, valid}, 8'd1);
    press_key();
    check("mul_ret", {6'd0, stage}, 8'd0);

    // Reset in the 2nd multiply cycle: no result may appear.
    sw = 4'h2;
    press_key();
    sw = 4'h3;
    press_key();
    sw = 4'h6;
    @(negedge clk);
    key_n = 1'b0;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i == 5) key_n = 1'b1;
        if (stage == 2'd3) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) check("mulrst_wait_timeout", {6'd0, stage}, 8'd3);
    end
    key_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mulrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mulrst_idle_stage", {6'd0, stage}, 8'd0);
    check("mulrst_idle_aluout", {4'd0, aluout}, 8'd0);

    run_op(4'h2, 4'h3, 3'd6, 4'h6, 1'b0, 1'b0, 3'd4, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
